// File: rtl/instruction_cache_pkg.sv
// Shared constants and types for the direct-mapped instruction cache.
package instruction_cache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MEM_READ,
        ST_UPDATE
    } icache_state_e;

    localparam logic [31:0] NOP_INSN          = 32'h0000_0013;
    localparam logic [31:0] PC_RESET_SENTINEL = 32'hFFFF_FFFC;
    localparam int          BLOCK_WORDS       = 4;
    localparam int          BLOCK_BITS        = 128;

endpackage

// File: rtl/icache_refill_fsm.sv
// Miss handling: IDLE -> MEM_READ (wait for memory) -> UPDATE (write line) -> IDLE.
module icache_refill_fsm
    import instruction_cache_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  miss_i,
    input  logic                  mem_busywait_i,
    input  logic [BLOCK_BITS-1:0] mem_readdata_i,
    output logic                  mem_read_o,
    output logic                  busy_wait_o,
    output logic                  fill_en_o,
    output logic [BLOCK_BITS-1:0] fill_data_o
);

    icache_state_e         state_q;
    logic                  mem_read_q;
    logic                  busy_q;
    logic                  fill_en_q;
    logic [BLOCK_BITS-1:0] fill_data_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            mem_read_q <= 1'b0;
            busy_q     <= 1'b0;
            fill_en_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (miss_i) begin
                        state_q    <= ST_MEM_READ;
                        mem_read_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                ST_MEM_READ: begin
                    if (!mem_busywait_i) begin
                        state_q    <= ST_UPDATE;
                        mem_read_q <= 1'b0;
                        fill_en_q  <= 1'b1;
                    end
                end
                ST_UPDATE: begin
                    state_q   <= ST_IDLE;
                    fill_en_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    mem_read_q <= 1'b0;
                    busy_q     <= 1'b0;
                    fill_en_q  <= 1'b0;
                end
            endcase
        end
    end

    // Refill block is captured in the cycle memory reports valid data.
    always_ff @(posedge CLK) begin
        if (state_q == ST_MEM_READ && !mem_busywait_i) begin
            fill_data_q <= mem_readdata_i;
        end
    end

    // The IDLE stall is combinational so the PC freezes in the same cycle a miss appears.
    assign busy_wait_o = !RESET && (busy_q || (state_q == ST_IDLE && miss_i));
    assign mem_read_o  = !RESET && mem_read_q;
    assign fill_en_o   = fill_en_q;
    assign fill_data_o = fill_data_q;

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache: tag/data/valid arrays and hit/word select.
module instruction_cache
    import instruction_cache_pkg::*;
#(
    parameter int LINES = 8
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [31:0]           address,
    output logic [31:0]           instruction,
    output logic                  busyWait,
    output logic                  mem_read,
    output logic [27:0]           mem_address,
    input  logic [BLOCK_BITS-1:0] mem_readdata,
    input  logic                  mem_busywait
);

    localparam int IW = $clog2(LINES);
    localparam int TW = 28 - IW;

    logic [1:0]            offset;
    logic [IW-1:0]         index;
    logic [TW-1:0]         tag;
    logic                  sentinel;
    logic                  hit;
    logic                  miss;
    logic                  fill_en;
    logic [BLOCK_BITS-1:0] fill_data;
    logic                  unused_addr_bits;

    logic [BLOCK_BITS-1:0] data_q [LINES];
    logic [TW-1:0]         tag_q  [LINES];
    logic [LINES-1:0]      valid_q;

    assign offset           = address[3:2];
    assign index            = address[4 +: IW];
    assign tag              = address[31:4+IW];
    assign unused_addr_bits = ^address[1:0];

    assign sentinel = (address[31:2] == PC_RESET_SENTINEL[31:2]);
    assign hit      = valid_q[index] && (tag_q[index] == tag);
    assign miss     = !hit && !sentinel;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid_q <= '0;
        end else if (fill_en) begin
            valid_q[index] <= 1'b1;
        end
    end

    // Address is stable through a miss, so the current index/tag name the line being filled.
    always_ff @(posedge CLK) begin
        if (fill_en && !RESET) begin
            data_q[index] <= fill_data;
            tag_q[index]  <= tag;
        end
    end

    assign instruction = sentinel ? NOP_INSN : data_q[index][{offset, 5'b0} +: 32];
    assign mem_address = address[31:4];

    icache_refill_fsm u_refill_fsm (
        .CLK            (CLK),
        .RESET          (RESET),
        .miss_i         (miss),
        .mem_busywait_i (mem_busywait),
        .mem_readdata_i (mem_readdata),
        .mem_read_o     (mem_read),
        .busy_wait_o    (busyWait),
        .fill_en_o      (fill_en),
        .fill_data_o    (fill_data)
    );

endmodule

// File: tb/tb_instruction_cache.sv
// Randomized bench for instruction_cache against a line-level cache model and memory responder.
module tb_instruction_cache;

    localparam int          LINES = 8;
    localparam logic [31:0] SENT  = 32'hFFFF_FFFC;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic         CLK;
    logic         RESET;
    logic [31:0]  address;
    logic [31:0]  instruction;
    logic         busyWait;
    logic         mem_read;
    logic [27:0]  mem_address;
    logic [127:0] mem_readdata;
    logic         mem_busywait;

    int checks = 0;
    int errors = 0;

    logic        ref_valid [LINES];
    logic [24:0] ref_tag   [LINES];

    instruction_cache #(.LINES(LINES)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .address      (address),
        .instruction  (instruction),
        .busyWait     (busyWait),
        .mem_read     (mem_read),
        .mem_address  (mem_address),
        .mem_readdata (mem_readdata),
        .mem_busywait (mem_busywait)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Backing memory: word at byte address a holds (a/4)+1, so block 0 is {4,3,2,1}.
    function automatic logic [31:0] mword(input logic [31:0] a);
        return {2'b00, a[31:2]} + 32'd1;
    endfunction

    function automatic logic [127:0] blk(input logic [27:0] b);
        logic [127:0] r;
        for (int k = 0; k < 4; k++) begin
            logic [1:0] kk;
            kk = k[1:0];
            r[k*32 +: 32] = mword({b, kk, 2'b00});
        end
        return r;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < LINES; i++) begin
            ref_valid[i] = 1'b0;
            ref_tag[i]   = '0;
        end
    endtask

    // Present one fetch; called just after a falling edge, returns just after a falling edge.
    task automatic fetch(input logic [31:0] a, input int lat);
        int         stalls;
        int         mr;
        int         exp_stalls;
        logic       sent;
        logic       hit;
        logic [2:0] idx;
        sent       = (a == SENT);
        idx        = a[6:4];
        hit        = ref_valid[idx] && (ref_tag[idx] == a[31:7]);
        exp_stalls = (sent || hit) ? 0 : lat + 2;
        address      = a;
        mem_busywait = 1'b1;
        mem_readdata = '0;
        stalls = 0;
        mr     = 0;
        for (int c = 0; c < 64; c++) begin
            #1;
            if (!busyWait) break;
            stalls++;
            if (mem_read) begin
                mr++;
                mem_busywait = (mr < lat);
                mem_readdata = mem_busywait ? ~blk(a[31:4]) : blk(a[31:4]);
                chk("mem_address", {4'h0, mem_address}, {4'h0, a[31:4]});
            end else begin
                mem_busywait = 1'b1;
                mem_readdata = '0;
            end
            @(negedge CLK);
        end
        chk("stall_cycles", stalls, exp_stalls);
        chk("mem_read_cycles", mr, (sent || hit) ? 0 : lat);
        chk("mem_read_on_serve", {31'd0, mem_read}, 32'd0);
        chk("instruction", instruction, sent ? NOP : mword(a));
        if (!sent && !hit) begin
            ref_valid[idx] = 1'b1;
            ref_tag[idx]   = a[31:7];
        end
        @(negedge CLK);
        mem_busywait = 1'b1;
    endtask

    // Start a miss on a, then assert reset during the second MEM_READ cycle.
    task automatic reset_mid(input logic [31:0] a);
        int mr;
        mr           = 0;
        address      = a;
        mem_busywait = 1'b1;
        for (int c = 0; c < 10 && mr < 2; c++) begin
            #1;
            if (mem_read) mr++;
            if (mr < 2) @(negedge CLK);
        end
        chk("rst_mid_reached", mr, 2);
        RESET = 1'b1;
        #1;
        chk("rst_busy_held", {31'd0, busyWait}, 32'd0);
        chk("rst_mem_read_held", {31'd0, mem_read}, 32'd0);
        @(negedge CLK);
        #1;
        chk("rst_after_edge_mem_read", {31'd0, mem_read}, 32'd0);
        RESET = 1'b0;
        clear_model();
    endtask

    initial begin
        logic [1:0] tsel;
        logic [2:0] idx;
        logic [1:0] off;
        logic [31:0] a;
        RESET        = 1'b1;
        address      = SENT;
        mem_busywait = 1'b1;
        mem_readdata = '0;
        clear_model();

        repeat (2) @(negedge CLK);
        #1;
        chk("reset_busy", {31'd0, busyWait}, 32'd0);
        chk("reset_mem_read", {31'd0, mem_read}, 32'd0);
        chk("reset_nop", instruction, NOP);
        address = 32'h0000_0000;
        #1;
        chk("reset_busy_nonsent", {31'd0, busyWait}, 32'd0);
        chk("reset_mem_read_nonsent", {31'd0, mem_read}, 32'd0);
        address = SENT;
        @(negedge CLK);
        RESET = 1'b0;

        fetch(SENT, 1);
        fetch(SENT, 1);

        fetch(32'h0000_0000, 5);
        fetch(32'h0000_0004, 1);
        fetch(32'h0000_0008, 1);
        fetch(32'h0000_000C, 1);

        fetch(32'h0000_0080, 2);
        fetch(32'h0000_0000, 3);

        reset_mid(32'h0000_0020);
        fetch(32'h0000_0020, 3);

        fetch(32'h0000_0000, 2);
        fetch(32'h0000_0010, 4);
        fetch(32'h0000_0000, 1);
        fetch(32'h0000_0010, 1);

        for (int n = 0; n < 120; n++) begin
            tsel = 2'($urandom_range(0, 3));
            idx  = 3'($urandom_range(0, 7));
            off  = 2'($urandom_range(0, 3));
            a    = {tsel[1], 22'd0, tsel, idx, off, 2'b00};
            if ($urandom_range(0, 15) == 0) a = SENT;
            fetch(a, $urandom_range(1, 6));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
